// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence transmitter and detectors.
// Contents: state encodings, the default idle line level, and a pattern-length clamp helper.
package seq_pkg;

   localparam logic [1:0] STATE_IDLE  = 2'b00;
   localparam logic [1:0] STATE_SHIFT = 2'b01;
   localparam logic [1:0] STATE_GAP   = 2'b10;
   localparam logic [1:0] STATE_DONE  = 2'b11;

   // A high idle line keeps zero-sensitive detectors quiet.
   localparam logic SEQ_IDLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = STATE_IDLE,
      SHIFT = STATE_SHIFT,
      GAP   = STATE_GAP,
      DONE  = STATE_DONE
   } seq_state_e;

   // Limit a requested length-minus-one to the physical register size.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
      return (len > width - 1) ? width - 1 : len;
   endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable left-shift PISO register for the pattern transmitter.
// Ports: clk/reset (sync, active-high); load takes data_in (priority over shift);
// shift moves the register one place left; msb_sel picks the bit presented on msb_c.
module seq_tx_shreg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic                     shift,
   input  logic [WIDTH-1:0]         data_in,
   input  logic [$clog2(WIDTH)-1:0] msb_sel,
   output logic                     msb_c
);

   logic [WIDTH-1:0] q;

   // Register update: load wins over shift.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= data_in;
      end else if (shift) begin
         q <= {q[WIDTH-2:0], 1'b0};
      end
   end

   // The active pattern's top bit sits at msb_sel, not always at WIDTH-1.
   assign msb_c = q[msb_sel];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends pattern MSB first, one bit per clk,
// repeated reps+1 times with GAP_CYCLES idle cycles between repeats.
// Ports: clk, reset (sync, active-high); start/pattern/len_m1/reps request a send
// (sampled in IDLE only); abort cancels; dout/dout_valid serial line;
// busy high outside IDLE; done pulses for one cycle after the final bit.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP_CYCLES = 2,
   parameter logic        IDLE_LEVEL = SEQ_IDLE_LEVEL
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [WIDTH-1:0]         pattern,
   input  logic [$clog2(WIDTH)-1:0] len_m1,
   input  logic [7:0]               reps,
   input  logic                     abort,
   output logic                     dout,
   output logic                     dout_valid,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned LW = $clog2(WIDTH);
   localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   seq_state_e        state_q, state_d;
   logic [LW-1:0]     bit_idx_q, bit_idx_d;
   logic [7:0]        rep_cnt_q, rep_cnt_d;
   logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0]  sh_pattern_q, sh_pattern_d;
   logic [LW-1:0]     sh_len_q, sh_len_d;
   logic              dout_d, dout_valid_d, busy_d, done_d;

   logic              sr_load_c, sr_shift_c, sr_msb_c;
   logic [WIDTH-1:0]  sr_data_c;
   logic [LW-1:0]     len_c;

   assign len_c = LW'(clamp_len(32'(len_m1), WIDTH));

   seq_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk     (clk),
      .reset   (reset),
      .load    (sr_load_c),
      .shift   (sr_shift_c),
      .data_in (sr_data_c),
      .msb_sel (sh_len_q),
      .msb_c   (sr_msb_c)
   );

   // State, counters, shadow copies and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         bit_idx_q    <= '0;
         rep_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         sh_pattern_q <= '0;
         sh_len_q     <= '0;
         dout         <= IDLE_LEVEL;
         dout_valid   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_idx_q    <= bit_idx_d;
         rep_cnt_q    <= rep_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         sh_pattern_q <= sh_pattern_d;
         sh_len_q     <= sh_len_d;
         dout         <= dout_d;
         dout_valid   <= dout_valid_d;
         busy         <= busy_d;
         done         <= done_d;
      end
   end

   // Next state and next output values. The first bit of every send is taken
   // straight from the pattern and the shifter is loaded one place ahead, so the
   // shifter's selected bit is always the next bit to transmit.
   always_comb begin
      state_d      = state_q;
      bit_idx_d    = bit_idx_q;
      rep_cnt_d    = rep_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      sh_pattern_d = sh_pattern_q;
      sh_len_d     = sh_len_q;
      sr_load_c    = 1'b0;
      sr_shift_c   = 1'b0;
      sr_data_c    = sh_pattern_q;
      dout_d       = IDLE_LEVEL;
      dout_valid_d = 1'b0;
      busy_d       = 1'b1;
      done_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start && !abort) begin
               state_d      = SHIFT;
               sh_pattern_d = pattern;
               sh_len_d     = len_c;
               rep_cnt_d    = reps;
               bit_idx_d    = len_c;
               sr_load_c    = 1'b1;
               sr_data_c    = pattern << 1;
               dout_d       = pattern[len_c];
               dout_valid_d = 1'b1;
               busy_d       = 1'b1;
            end
         end

         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (bit_idx_q != '0) begin
               bit_idx_d    = bit_idx_q - LW'(1);
               sr_shift_c   = 1'b1;
               dout_d       = sr_msb_c;
               dout_valid_d = 1'b1;
            end else if (rep_cnt_q == 8'd0) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               rep_cnt_d = rep_cnt_q - 8'd1;
               if (GAP_CYCLES == 0) begin
                  // Back-to-back repeat: next pattern's first bit follows immediately.
                  bit_idx_d    = sh_len_q;
                  sr_load_c    = 1'b1;
                  sr_data_c    = sh_pattern_q << 1;
                  dout_d       = sh_pattern_q[sh_len_q];
                  dout_valid_d = 1'b1;
               end else begin
                  state_d   = GAP;
                  gap_cnt_d = GW'(GAP_CYCLES - 1);
                  sr_load_c = 1'b1;
                  sr_data_c = sh_pattern_q;
               end
            end
         end

         GAP: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (gap_cnt_q == '0) begin
               state_d      = SHIFT;
               bit_idx_d    = sh_len_q;
               sr_shift_c   = 1'b1;
               dout_d       = sr_msb_c;
               dout_valid_d = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - GW'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule
